// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage: RV32I opcode/funct
// encodings, ALU operation/class encodings and the stage state type.
package id_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_AND  = 5'd5,
        ALU_OR   = 5'd6,
        ALU_XOR  = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_JAL  = 5'd11,
        ALU_JALR = 5'd12,
        ALU_BEQ  = 5'd13,
        ALU_BNE  = 5'd14,
        ALU_BLT  = 5'd15,
        ALU_BGE  = 5'd16,
        ALU_BLTU = 5'd17,
        ALU_BGEU = 5'd18,
        ALU_LB   = 5'd19,
        ALU_LH   = 5'd20,
        ALU_LW   = 5'd21,
        ALU_LBU  = 5'd22,
        ALU_LHU  = 5'd23,
        ALU_SB   = 5'd24,
        ALU_SH   = 5'd25,
        ALU_SW   = 5'd26
    } alu_op_e;

    typedef enum logic [2:0] {
        SEL_NOP    = 3'd0,
        SEL_ARITH  = 3'd1,
        SEL_LOGIC  = 3'd2,
        SEL_SHIFT  = 3'd3,
        SEL_JUMP   = 3'd4,
        SEL_BRANCH = 3'd5,
        SEL_LOAD   = 3'd6,
        SEL_STORE  = 3'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_REG  = 2'd1,
        OP1_PC   = 2'd2
    } op1_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } id_state_e;

    // alt selects SUB/SRA; callers must only raise it where funct7 is meaningful.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_NOP;
        endcase
    endfunction

    function automatic alu_sel_e arith_sel(input logic [2:0] f3);
        case (f3)
            F3_SLL, F3_SR:         return SEL_SHIFT;
            F3_XOR, F3_OR, F3_AND: return SEL_LOGIC;
            default:               return SEL_ARITH;
        endcase
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding selector: picks the nearest matching writer (lowest
// index), falls back to regfile data, and flags a load-use hazard.
module id_fwd_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NFWD = 2
) (
    input  logic                 read_i,
    input  logic [4:0]           addr_i,
    input  logic [XLEN-1:0]      rf_data_i,
    input  logic [NFWD-1:0]      fwd_wreg_i,
    input  logic [5*NFWD-1:0]    fwd_wd_i,
    input  logic [XLEN*NFWD-1:0] fwd_wdata_i,
    input  logic [NFWD-1:0]      fwd_ld_i,
    output logic [XLEN-1:0]      data_o,
    output logic                 hazard_o
);

    logic hit;

    always_comb begin
        data_o   = rf_data_i;
        hazard_o = 1'b0;
        hit      = 1'b0;
        if (addr_i == 5'd0) begin
            data_o = '0;
        end else begin
            for (int unsigned i = 0; i < NFWD; i++) begin
                if (!hit && fwd_wreg_i[i] && (fwd_wd_i[5*i +: 5] == addr_i)) begin
                    hit      = 1'b1;
                    data_o   = fwd_wdata_i[XLEN*i +: XLEN];
                    hazard_o = read_i & fwd_ld_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: combinational decode and operand forwarding,
// one output register slot with valid/ready handshake, load-use stall and flush.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          inst_i,
    output logic                 reg1_read_o,
    output logic                 reg2_read_o,
    output logic [4:0]           reg1_addr_o,
    output logic [4:0]           reg2_addr_o,
    input  logic [XLEN-1:0]      reg1_data_i,
    input  logic [XLEN-1:0]      reg2_data_i,
    input  logic [NFWD-1:0]      fwd_wreg_i,
    input  logic [5*NFWD-1:0]    fwd_wd_i,
    input  logic [XLEN*NFWD-1:0] fwd_wdata_i,
    input  logic [NFWD-1:0]      fwd_ld_i,
    input  logic                 flush_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output alu_op_e              aluop_o,
    output alu_sel_e             alusel_o,
    output logic [XLEN-1:0]      reg1_o,
    output logic [XLEN-1:0]      reg2_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [4:0]           wd_o,
    output logic                 wreg_o,
    output logic [XLEN-1:0]      pc_o,
    output logic                 illegal_o,
    output logic [7:0]           stall_cnt_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    alu_op_e     dec_aluop;
    alu_sel_e    dec_alusel;
    op1_sel_e    dec_op1;
    logic [31:0] dec_imm32;
    logic        dec_wreg;
    logic        dec_ill;
    logic        dec_r1_rd;
    logic        dec_r2_rd;
    logic        dec_r2_imm;

    always_comb begin
        dec_aluop  = ALU_NOP;
        dec_alusel = SEL_NOP;
        dec_op1    = OP1_REG;
        dec_imm32  = '0;
        dec_wreg   = 1'b0;
        dec_ill    = 1'b0;
        dec_r1_rd  = 1'b0;
        dec_r2_rd  = 1'b0;
        dec_r2_imm = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_aluop  = ALU_ADD;
                dec_alusel = SEL_ARITH;
                dec_imm32  = {inst_i[31:12], 12'b0};
                dec_wreg   = 1'b1;
                dec_r2_imm = 1'b1;
                dec_op1    = (opcode == OPC_LUI) ? OP1_ZERO : OP1_PC;
            end
            OPC_JAL: begin
                dec_aluop  = ALU_JAL;
                dec_alusel = SEL_JUMP;
                dec_imm32  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
                dec_wreg   = 1'b1;
                dec_r2_imm = 1'b1;
                dec_op1    = OP1_PC;
            end
            OPC_JALR: begin
                dec_aluop  = ALU_JALR;
                dec_alusel = SEL_JUMP;
                dec_imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
                dec_wreg   = 1'b1;
                dec_r1_rd  = 1'b1;
                dec_r2_imm = 1'b1;
                dec_ill    = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_alusel = SEL_BRANCH;
                dec_imm32  = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
                dec_r1_rd  = 1'b1;
                dec_r2_rd  = 1'b1;
                case (funct3)
                    F3_BEQ:  dec_aluop = ALU_BEQ;
                    F3_BNE:  dec_aluop = ALU_BNE;
                    F3_BLT:  dec_aluop = ALU_BLT;
                    F3_BGE:  dec_aluop = ALU_BGE;
                    F3_BLTU: dec_aluop = ALU_BLTU;
                    F3_BGEU: dec_aluop = ALU_BGEU;
                    default: dec_ill   = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_alusel = SEL_LOAD;
                dec_imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
                dec_wreg   = 1'b1;
                dec_r1_rd  = 1'b1;
                dec_r2_imm = 1'b1;
                case (funct3)
                    F3_B:    dec_aluop = ALU_LB;
                    F3_H:    dec_aluop = ALU_LH;
                    F3_W:    dec_aluop = ALU_LW;
                    F3_BU:   dec_aluop = ALU_LBU;
                    F3_HU:   dec_aluop = ALU_LHU;
                    default: dec_ill   = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_alusel = SEL_STORE;
                dec_imm32  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                dec_r1_rd  = 1'b1;
                dec_r2_rd  = 1'b1;
                case (funct3)
                    F3_B:    dec_aluop = ALU_SB;
                    F3_H:    dec_aluop = ALU_SH;
                    F3_W:    dec_aluop = ALU_SW;
                    default: dec_ill   = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                // funct7 only qualifies the shift forms; elsewhere it is immediate bits
                dec_aluop  = arith_op(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
                dec_alusel = arith_sel(funct3);
                dec_wreg   = 1'b1;
                dec_r1_rd  = 1'b1;
                dec_r2_imm = 1'b1;
                if (funct3 == F3_SLL || funct3 == F3_SR)
                    dec_imm32 = {27'b0, inst_i[24:20]};
                else
                    dec_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                if (funct3 == F3_SLL)
                    dec_ill = (funct7 != F7_BASE);
                else if (funct3 == F3_SR)
                    dec_ill = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
            OPC_OP: begin
                dec_aluop  = arith_op(funct3, funct7 == F7_ALT);
                dec_alusel = arith_sel(funct3);
                dec_wreg   = 1'b1;
                dec_r1_rd  = 1'b1;
                dec_r2_rd  = 1'b1;
                dec_ill    = !((funct7 == F7_BASE) ||
                               ((funct7 == F7_ALT) && (funct3 == F3_ADD || funct3 == F3_SR)));
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_aluop  = ALU_NOP;
            dec_alusel = SEL_NOP;
            dec_op1    = OP1_ZERO;
            dec_imm32  = '0;
            dec_wreg   = 1'b0;
            dec_r1_rd  = 1'b0;
            dec_r2_rd  = 1'b0;
            dec_r2_imm = 1'b0;
        end
    end

    assign reg1_read_o = in_valid & dec_r1_rd;
    assign reg2_read_o = in_valid & dec_r2_rd;
    assign reg1_addr_o = inst_i[19:15];
    assign reg2_addr_o = inst_i[24:20];

    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
    logic            haz1;
    logic            haz2;

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd1 (
        .read_i      (reg1_read_o),
        .addr_i      (reg1_addr_o),
        .rf_data_i   (reg1_data_i),
        .fwd_wreg_i  (fwd_wreg_i),
        .fwd_wd_i    (fwd_wd_i),
        .fwd_wdata_i (fwd_wdata_i),
        .fwd_ld_i    (fwd_ld_i),
        .data_o      (fwd1_data),
        .hazard_o    (haz1)
    );

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd2 (
        .read_i      (reg2_read_o),
        .addr_i      (reg2_addr_o),
        .rf_data_i   (reg2_data_i),
        .fwd_wreg_i  (fwd_wreg_i),
        .fwd_wd_i    (fwd_wd_i),
        .fwd_wdata_i (fwd_wdata_i),
        .fwd_ld_i    (fwd_ld_i),
        .data_o      (fwd2_data),
        .hazard_o    (haz2)
    );

    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] op1_val;
    logic [XLEN-1:0] op2_val;

    assign imm_x = XLEN'(signed'(dec_imm32));

    always_comb begin
        op1_val = fwd1_data;
        case (dec_op1)
            OP1_ZERO: op1_val = '0;
            OP1_PC:   op1_val = pc_i;
            default:  op1_val = fwd1_data;
        endcase
        op2_val = '0;
        if (dec_r2_imm)
            op2_val = imm_x;
        else if (dec_r2_rd)
            op2_val = fwd2_data;
    end

    logic            out_valid_q, out_valid_d;
    logic [7:0]      stall_cnt_q, stall_cnt_d;
    id_state_e       state_q, state_d;
    alu_op_e         aluop_q;
    alu_sel_e        alusel_q;
    logic [XLEN-1:0] reg1_q, reg2_q, imm_q, pc_q;
    logic [4:0]      wd_q;
    logic            wreg_q, illegal_q;
    logic            hazard, slot_free, accept;

    assign hazard    = haz1 | haz2;
    assign slot_free = ~out_valid_q | out_ready;
    assign in_ready  = flush_i | (slot_free & ~hazard);
    assign accept    = in_valid & in_ready & ~flush_i;

    always_comb begin
        out_valid_d = out_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (slot_free) begin
            // either the consumer drained the slot or a bubble replaces a stalled issue
            out_valid_d = 1'b0;
            if (hazard && stall_cnt_q != 8'hFF)
                stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (hazard && !flush_i) state_d = ST_STALL;
            ST_STALL: if (!hazard || flush_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            state_q     <= ST_RUN;
            aluop_q     <= ALU_NOP;
            alusel_q    <= SEL_NOP;
            reg1_q      <= '0;
            reg2_q      <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            state_q     <= state_d;
            if (accept) begin
                aluop_q   <= dec_aluop;
                alusel_q  <= dec_alusel;
                reg1_q    <= op1_val;
                reg2_q    <= op2_val;
                imm_q     <= imm_x;
                pc_q      <= pc_i;
                wd_q      <= dec_wreg ? inst_i[11:7] : 5'd0;
                wreg_q    <= dec_wreg;
                illegal_q <= dec_ill;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign stall_cnt_o = stall_cnt_q;
    assign aluop_o     = aluop_q;
    assign alusel_o    = alusel_q;
    assign reg1_o      = reg1_q;
    assign reg2_o      = reg2_q;
    assign imm_o       = imm_q;
    assign pc_o        = pc_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, forwarding, load-use stall,
// backpressure, flush, illegal decode and asynchronous reset.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic [1:0]  fwd_wreg_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic [1:0]  fwd_ld_i;
    logic        flush_i;
    logic        out_valid;
    logic        out_ready;
    alu_op_e     aluop_o;
    alu_sel_e    alusel_o;
    logic [31:0] reg1_o, reg2_o, imm_o, pc_o;
    logic [4:0]  wd_o;
    logic        wreg_o, illegal_o;
    logic [7:0]  stall_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    id_stage #(.XLEN(32), .NFWD(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc_i        (pc_i),
        .inst_i      (inst_i),
        .reg1_read_o (reg1_read_o),
        .reg2_read_o (reg2_read_o),
        .reg1_addr_o (reg1_addr_o),
        .reg2_addr_o (reg2_addr_o),
        .reg1_data_i (reg1_data_i),
        .reg2_data_i (reg2_data_i),
        .fwd_wreg_i  (fwd_wreg_i),
        .fwd_wd_i    (fwd_wd_i),
        .fwd_wdata_i (fwd_wdata_i),
        .fwd_ld_i    (fwd_ld_i),
        .flush_i     (flush_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluop_o     (aluop_o),
        .alusel_o    (alusel_o),
        .reg1_o      (reg1_o),
        .reg2_o      (reg2_o),
        .imm_o       (imm_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .pc_o        (pc_o),
        .illegal_o   (illegal_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_wreg_i  = '0;
        fwd_wd_i    = '0;
        fwd_wdata_i = '0;
        fwd_ld_i    = '0;
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        pc_i        = '0;
        inst_i      = 32'h0000_0013;
        reg1_data_i = '0;
        reg2_data_i = '0;
        flush_i     = 1'b0;
        out_ready   = 1'b1;
        clear_fwd();

        #3;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_stall_cnt", stall_cnt_o, 0);
        check_eq("rst_reg1", reg1_o, 0);
        check_eq("rst_aluop", aluop_o, ALU_NOP);
        check_eq("rst_wreg", wreg_o, 0);

        // ADDI x1,x0,-1 accepted on the first edge after reset release
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        inst_i   = 32'hFFF0_0093;
        pc_i     = 32'h100;
        #1;
        check_eq("addi_in_ready", in_ready, 1);
        check_eq("addi_r1_read", reg1_read_o, 1);
        check_eq("addi_r2_read", reg2_read_o, 0);
        tick();
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_aluop", aluop_o, ALU_ADD);
        check_eq("addi_reg1", reg1_o, 0);
        check_eq("addi_reg2", reg2_o, 32'hFFFF_FFFF);
        check_eq("addi_imm", imm_o, 32'hFFFF_FFFF);
        check_eq("addi_wd", wd_o, 1);
        check_eq("addi_wreg", wreg_o, 1);
        check_eq("addi_pc", pc_o, 32'h100);
        check_eq("addi_illegal", illegal_o, 0);

        // ADD x3,x1,x2 with two writers of x1: nearest one wins
        inst_i      = 32'h0020_81B3;
        reg1_data_i = 32'h99;
        reg2_data_i = 32'h5;
        fwd_wreg_i  = 2'b11;
        fwd_wd_i    = {5'd1, 5'd1};
        fwd_wdata_i = {32'h22, 32'h11};
        #1;
        check_eq("add_r2_addr", reg2_addr_o, 2);
        tick();
        check_eq("add_fwd0_reg1", reg1_o, 32'h11);
        check_eq("add_fwd0_reg2", reg2_o, 32'h5);
        check_eq("add_wd", wd_o, 3);

        fwd_wreg_i = 2'b10;
        tick();
        check_eq("add_fwd1_reg1", reg1_o, 32'h22);

        // SUB x5,x6,x7 with rs2 forwarded from source 1
        inst_i      = 32'h4073_02B3;
        reg1_data_i = 32'h1234;
        fwd_wreg_i  = 2'b10;
        fwd_wd_i    = {5'd7, 5'd0};
        fwd_wdata_i = {32'hABCD, 32'h0};
        tick();
        check_eq("sub_aluop", aluop_o, ALU_SUB);
        check_eq("sub_reg1", reg1_o, 32'h1234);
        check_eq("sub_reg2", reg2_o, 32'hABCD);

        // x0 is never forwarded and never causes a hazard
        inst_i      = 32'h0020_01B3;
        reg1_data_i = 32'h77;
        fwd_wreg_i  = 2'b01;
        fwd_wd_i    = {5'd0, 5'd0};
        fwd_wdata_i = {32'h0, 32'hDEAD};
        fwd_ld_i    = 2'b01;
        #1;
        check_eq("x0_in_ready", in_ready, 1);
        tick();
        check_eq("x0_reg1", reg1_o, 0);
        clear_fwd();

        // LUI / AUIPC / SRAI operand and immediate selection
        inst_i = 32'h1234_53B7;
        tick();
        check_eq("lui_reg1", reg1_o, 0);
        check_eq("lui_reg2", reg2_o, 32'h1234_5000);
        inst_i = 32'h0000_1417;
        pc_i   = 32'h200;
        tick();
        check_eq("auipc_reg1", reg1_o, 32'h200);
        check_eq("auipc_reg2", reg2_o, 32'h1000);
        check_eq("auipc_wd", wd_o, 8);
        inst_i = 32'h4035_5493;
        tick();
        check_eq("srai_aluop", aluop_o, ALU_SRA);
        check_eq("srai_alusel", alusel_o, SEL_SHIFT);
        check_eq("srai_imm", imm_o, 3);

        // load-use: ADD x3,x1,x2 while x1 is a pending load in source 0
        inst_i      = 32'h0020_81B3;
        reg1_data_i = 32'h99;
        fwd_wreg_i  = 2'b01;
        fwd_wd_i    = {5'd0, 5'd1};
        fwd_wdata_i = {32'h0, 32'h55};
        fwd_ld_i    = 2'b01;
        #1;
        check_eq("lu_in_ready", in_ready, 0);
        tick();
        check_eq("lu_bubble", out_valid, 0);
        check_eq("lu_stall_cnt", stall_cnt_o, 1);
        check_eq("lu_state", dut.state_q, ST_STALL);
        fwd_ld_i = 2'b00;
        #1;
        check_eq("lu_release_ready", in_ready, 1);
        tick();
        check_eq("lu_issue_valid", out_valid, 1);
        check_eq("lu_issue_reg1", reg1_o, 32'h55);
        check_eq("lu_stall_hold", stall_cnt_o, 1);
        check_eq("lu_state_run", dut.state_q, ST_RUN);

        // nearer non-load writer shadows a farther pending load
        reg1_data_i = 32'h10;
        fwd_wreg_i  = 2'b11;
        fwd_wd_i    = {5'd2, 5'd2};
        fwd_wdata_i = {32'h77, 32'h66};
        fwd_ld_i    = 2'b10;
        #1;
        check_eq("prio_in_ready", in_ready, 1);
        tick();
        check_eq("prio_reg2", reg2_o, 32'h66);
        check_eq("prio_reg1", reg1_o, 32'h10);
        clear_fwd();

        // backpressure: ANDI held for three cycles while ORI waits
        inst_i      = 32'h0F02_F213;
        reg1_data_i = 32'h3C;
        tick();
        check_eq("andi_aluop", aluop_o, ALU_AND);
        out_ready = 1'b0;
        inst_i    = 32'h0050_6313;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("bp_in_ready", in_ready, 0);
            tick();
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_aluop", aluop_o, ALU_AND);
            check_eq("bp_reg1", reg1_o, 32'h3C);
            check_eq("bp_reg2", reg2_o, 32'hF0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", in_ready, 1);
        tick();
        check_eq("ori_aluop", aluop_o, ALU_OR);
        check_eq("ori_reg2", reg2_o, 5);
        check_eq("ori_wd", wd_o, 6);

        // long stall saturates the counter, then flush kills the waiting instruction
        inst_i      = 32'h0020_81B3;
        fwd_wreg_i  = 2'b01;
        fwd_wd_i    = {5'd0, 5'd1};
        fwd_ld_i    = 2'b01;
        tick();
        check_eq("st_bubble", out_valid, 0);
        check_eq("st_cnt2", stall_cnt_o, 2);
        repeat (260) tick();
        check_eq("st_saturate", stall_cnt_o, 255);
        check_eq("st_state", dut.state_q, ST_STALL);
        flush_i = 1'b1;
        #1;
        check_eq("fl_in_ready", in_ready, 1);
        tick();
        check_eq("fl_valid", out_valid, 0);
        check_eq("fl_state", dut.state_q, ST_RUN);
        check_eq("fl_cnt", stall_cnt_o, 255);
        flush_i  = 1'b0;
        in_valid = 1'b0;
        clear_fwd();
        tick();
        check_eq("fl_lost", out_valid, 0);

        // illegal encodings still issue, with no register write
        in_valid = 1'b1;
        inst_i   = 32'hFFFF_FFFF;
        tick();
        check_eq("ill_valid", out_valid, 1);
        check_eq("ill_flag", illegal_o, 1);
        check_eq("ill_wreg", wreg_o, 0);
        check_eq("ill_aluop", aluop_o, ALU_NOP);
        inst_i = 32'h0220_81B3;
        tick();
        check_eq("ill_f7_flag", illegal_o, 1);
        check_eq("ill_f7_valid", out_valid, 1);

        // asynchronous reset while holding an output
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        check_eq("hold_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_illegal", illegal_o, 0);
        check_eq("arst_cnt", stall_cnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
